// File: rtl/mf_frame_sequencer.sv
// mf_frame_sequencer
//   Cuts a free-running paired ADC/DAC IQ sample stream into FFT_LEN-sample
//   frames, one frame per accepted chirp trigger, and forwards them to the
//   matched-filter correlator with first/last markers and a 64-bit frame ID.
//   Limits frames in flight until peak results return, recovers lost results
//   with a watchdog and counts rejected triggers.
//
// Ports
//   aclk, areset           clock, synchronous active-high reset
//   enable, trigger        frame start permission (level) and chirp pulse
//   timeout_cycles         result watchdog limit, 0 disables it
//   s_adc/dac_tdata,
//   s_tvalid, s_tready     upstream sample pair stream
//   m_adc/dac_tdata,
//   m_tvalid, m_tlast,
//   m_first, m_tready      framed stream to the correlator
//   m_counter_id           ID of the frame currently being issued
//   result_done            peak result accepted downstream
//   busy, outstanding      FSM not idle, frames awaiting a result
//   drop_count,
//   timeout_count,
//   timeout_pulse          saturating status counters and expiry strobe

module mf_frame_sequencer #(
   parameter int unsigned FFT_LEN         = 4096,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_WIDTH       = 32
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 enable,
   input  logic                 trigger,
   input  logic [31:0]          timeout_cycles,
   input  logic [31:0]          s_adc_tdata,
   input  logic [31:0]          s_dac_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   output logic [31:0]          m_adc_tdata,
   output logic [31:0]          m_dac_tdata,
   output logic                 m_tvalid,
   output logic                 m_tlast,
   output logic                 m_first,
   input  logic                 m_tready,
   output logic [63:0]          m_counter_id,
   input  logic                 result_done,
   output logic                 busy,
   output logic [3:0]           outstanding,
   output logic [CNT_WIDTH-1:0] drop_count,
   output logic [CNT_WIDTH-1:0] timeout_count,
   output logic                 timeout_pulse
);

   localparam int unsigned BW = $clog2(FFT_LEN);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_WAIT_RESULT
   } state_t;

   state_t               r_state;
   logic [BW-1:0]        r_beat;
   logic [31:0]          r_wdog;
   logic [3:0]           r_out;
   logic [63:0]          r_id;
   logic [CNT_WIDTH-1:0] r_drop;
   logic [CNT_WIDTH-1:0] r_tocnt;
   logic                 r_tpulse;

   logic                 w_in_stream;
   logic                 w_xfer;
   logic                 w_last_beat;
   logic                 w_last_xfer;
   logic                 w_start;
   logic                 w_drop;
   logic                 w_expire;
   logic                 w_dec;
   logic [3:0]           w_out_next;

   assign w_in_stream = (r_state == ST_STREAM);
   assign w_xfer      = w_in_stream & s_tvalid & m_tready;
   assign w_last_beat = (r_beat == BW'(FFT_LEN - 1));
   assign w_last_xfer = w_xfer & w_last_beat;
   assign w_start     = (r_state == ST_IDLE) & trigger & enable &
                        (r_out < 4'(MAX_OUTSTANDING));
   // Any trigger that does not start a frame is a drop, whatever the state.
   assign w_drop      = trigger & ~w_start;
   assign w_expire    = (r_state == ST_WAIT_RESULT) & (timeout_cycles != '0) &
                        (r_wdog == timeout_cycles - 32'd1);
   // A result with nothing in flight is ignored so the count cannot underflow.
   assign w_dec       = result_done & (r_out != '0);

   // Frames-in-flight update; the frame-end state choice looks at this value
   // so a coincident result_done is already accounted for.
   always_comb begin
      w_out_next = r_out;
      if (w_expire)
         w_out_next = '0;
      else if (w_last_xfer && !w_dec)
         w_out_next = r_out + 4'd1;
      else if (!w_last_xfer && w_dec)
         w_out_next = r_out - 4'd1;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state  <= ST_IDLE;
         r_beat   <= '0;
         r_wdog   <= '0;
         r_out    <= '0;
         r_id     <= '0;
         r_drop   <= '0;
         r_tocnt  <= '0;
         r_tpulse <= 1'b0;
      end else begin
         r_tpulse <= 1'b0;
         r_out    <= w_out_next;
         if (w_drop && (r_drop != '1))
            r_drop <= r_drop + CNT_WIDTH'(1);

         case (r_state)
            ST_IDLE: begin
               r_wdog <= '0;
               if (w_start) begin
                  r_state <= ST_STREAM;
                  r_beat  <= '0;
               end
            end

            ST_STREAM: begin
               if (w_xfer) begin
                  if (w_last_beat) begin
                     r_beat  <= '0;
                     // ID advances after the last beat so it is stable for the frame.
                     r_id    <= r_id + 64'd1;
                     r_state <= (w_out_next == 4'(MAX_OUTSTANDING)) ?
                                ST_WAIT_RESULT : ST_IDLE;
                  end else begin
                     r_beat <= r_beat + BW'(1);
                  end
               end
            end

            ST_WAIT_RESULT: begin
               r_wdog <= r_wdog + 32'd1;
               if (w_expire) begin
                  r_tpulse <= 1'b1;
                  if (r_tocnt != '1)
                     r_tocnt <= r_tocnt + CNT_WIDTH'(1);
                  r_state  <= ST_IDLE;
                  r_wdog   <= '0;
               end else if (result_done) begin
                  r_state <= ST_IDLE;
                  r_wdog  <= '0;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Zero-latency pass-through while streaming; otherwise samples are sunk.
   assign s_tready      = w_in_stream ? m_tready : 1'b1;
   assign m_adc_tdata   = s_adc_tdata;
   assign m_dac_tdata   = s_dac_tdata;
   assign m_tvalid      = w_in_stream & s_tvalid;
   assign m_first       = w_in_stream & (r_beat == '0);
   assign m_tlast       = w_in_stream & w_last_beat;
   assign m_counter_id  = r_id;
   assign busy          = (r_state != ST_IDLE);
   assign outstanding   = r_out;
   assign drop_count    = r_drop;
   assign timeout_count = r_tocnt;
   assign timeout_pulse = r_tpulse;

endmodule
